// File: rtl/chardisp_console_pkg.sv
// chardisp_console_pkg: shared geometry defaults, control codes, FSM states and cell-word packing
package chardisp_console_pkg;
    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 50;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {CLRALL, IDLE, PUT, CLRROW} state_t;

    function automatic logic [31:0] cell_word(input logic [7:0] ch, input logic [2:0] color);
        return {21'b0, color, ch};
    endfunction
endpackage

// File: rtl/chardisp_console_if.sv
// chardisp_console_if: character input handshake, cursor status and VRAM write port
interface chardisp_console_if;
    logic        CH_VALID;
    logic        CH_READY;
    logic [7:0]  CH_DATA;
    logic [2:0]  COLOR;
    logic        BUSY;
    logic [6:0]  CURSOR_X;
    logic [5:0]  CURSOR_Y;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WRDATA;

    modport master (
        output CH_VALID, CH_DATA, COLOR,
        input  CH_READY, BUSY, CURSOR_X, CURSOR_Y, WRADDR, BYTEEN, WREN, WRDATA
    );
    modport slave (
        input  CH_VALID, CH_DATA, COLOR,
        output CH_READY, BUSY, CURSOR_X, CURSOR_Y, WRADDR, BYTEEN, WREN, WRDATA
    );
endinterface

// File: rtl/chardisp_console.sv
// chardisp_console: byte-stream text console writing character cells into chardisp VRAM
module chardisp_console
    import chardisp_console_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    chardisp_console_if.slave  bus
);
    localparam logic [6:0]  XMAX = 7'(COLS - 1);
    localparam logic [5:0]  YMAX = 6'(ROWS - 1);
    localparam logic [15:0] ROWB = 16'(COLS * 4);
    localparam logic [15:0] LAST = 16'((COLS * ROWS - 1) * 4);

    state_t      state_q;
    logic [6:0]  x_q, wx_q;
    logic [5:0]  y_q;
    logic [15:0] row_q, cur_q, addr_q;
    logic [2:0]  color_q;
    logic        wren_q;
    logic [31:0] wdata_q;
    logic [5:0]  ny_d;
    logic [15:0] nrow_d;
    logic        printable;

    // Row index and row base address the cursor moves to on a newline (wraps to the top)
    always_comb begin
        ny_d      = (y_q == YMAX) ? '0 : y_q + 6'd1;
        nrow_d    = (y_q == YMAX) ? '0 : row_q + ROWB;
        printable = (bus.CH_DATA >= 8'h20) && (bus.CH_DATA <= 8'h7E);
    end

    assign bus.CH_READY = (state_q == IDLE);
    assign bus.BUSY     = (state_q != IDLE);
    assign bus.CURSOR_X = x_q;
    assign bus.CURSOR_Y = y_q;
    assign bus.WRADDR   = addr_q;
    assign bus.WREN     = wren_q;
    assign bus.WRDATA   = wdata_q;
    assign bus.BYTEEN   = {4{wren_q}};

    // Console FSM: clears alternate strobe-high/strobe-low cycles; cursor commits when a sequence ends
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLRALL;
            x_q     <= '0;
            y_q     <= '0;
            wx_q    <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            addr_q  <= '0;
            color_q <= 3'b111;
            wren_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.CH_VALID) begin
                        color_q <= bus.COLOR;
                        if (printable) begin
                            state_q <= PUT;
                            wren_q  <= 1'b1;
                            addr_q  <= cur_q;
                            wdata_q <= cell_word(bus.CH_DATA, bus.COLOR);
                        end else if (bus.CH_DATA == LF) begin
                            state_q <= CLRROW;
                            addr_q  <= nrow_d;
                            wx_q    <= '0;
                        end else if (bus.CH_DATA == FF) begin
                            state_q <= CLRALL;
                            addr_q  <= '0;
                        end else if (bus.CH_DATA == CR) begin
                            x_q   <= '0;
                            cur_q <= row_q;
                        end else if (bus.CH_DATA == BS && x_q != '0) begin
                            x_q   <= x_q - 7'd1;
                            cur_q <= cur_q - 16'd4;
                        end
                    end
                end
                PUT: begin
                    wren_q <= 1'b0;
                    if (x_q == XMAX) begin
                        state_q <= CLRROW;
                        addr_q  <= nrow_d;
                        wx_q    <= '0;
                    end else begin
                        state_q <= IDLE;
                        x_q     <= x_q + 7'd1;
                        cur_q   <= cur_q + 16'd4;
                    end
                end
                CLRROW: begin
                    if (!wren_q) begin
                        wren_q  <= 1'b1;
                        wdata_q <= cell_word(SPACE, color_q);
                    end else begin
                        wren_q <= 1'b0;
                        if (wx_q == XMAX) begin
                            state_q <= IDLE;
                            x_q     <= '0;
                            y_q     <= ny_d;
                            row_q   <= nrow_d;
                            cur_q   <= nrow_d;
                        end else begin
                            wx_q   <= wx_q + 7'd1;
                            addr_q <= addr_q + 16'd4;
                        end
                    end
                end
                CLRALL: begin
                    if (!wren_q) begin
                        wren_q  <= 1'b1;
                        wdata_q <= cell_word(SPACE, color_q);
                    end else begin
                        wren_q <= 1'b0;
                        if (addr_q == LAST) begin
                            state_q <= IDLE;
                            x_q     <= '0;
                            y_q     <= '0;
                            row_q   <= '0;
                            cur_q   <= '0;
                        end else begin
                            addr_q <= addr_q + 16'd4;
                        end
                    end
                end
                default: state_q <= CLRALL;
            endcase
        end
    end
endmodule

// File: tb/tb_chardisp_console.sv
// tb_chardisp_console: directed table, corner sequences and random bytes checked against a cell-level model
module tb_chardisp_console;
    localparam int COLS = 80;
    localparam int ROWS = 50;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0]  d;
        logic [2:0]  c;
        int          ex;
        int          ey;
        int          nw;
        logic [15:0] la;
        logic [31:0] ld;
        logic        rdy;
        logic        wr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   proto_err;
    int   proto_seen;
    logic prev_wren;
    logic rdy_after;
    logic wr_after;
    wr_t  cap_q[$];
    wr_t  exp_q[$];
    int   mx;
    int   my;
    logic [2:0] mc;

    chardisp_console_if bus();

    chardisp_console dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every VRAM write and flag strobe-protocol violations
    always @(negedge clk) begin
        if (rst) begin
            prev_wren <= 1'b0;
        end else begin
            prev_wren <= bus.WREN;
            if (bus.WREN) begin
                cap_q.push_back({bus.WRADDR, bus.WRDATA});
                if (prev_wren || bus.BYTEEN != 4'hF || bus.WRADDR >= 16'(COLS * ROWS * 4)) begin
                    proto_err <= proto_err + 1;
                    $display("protocol violation at %0t: prev_wren=%0b byteen=%h addr=%0d", $time, prev_wren, bus.BYTEEN, bus.WRADDR);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_cell(input int x, input int y, input logic [7:0] ch);
        wr_t w;
        w.a = 16'((y * COLS + x) * 4);
        w.d = {21'b0, mc, ch};
        exp_q.push_back(w);
    endtask

    task automatic model_nl();
        my = (my == ROWS - 1) ? 0 : my + 1;
        for (int x = 0; x < COLS; x++) push_cell(x, my, 8'h20);
    endtask

    task automatic model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) push_cell(x, y, 8'h20);
        mx = 0;
        my = 0;
    endtask

    task automatic model_byte(input logic [7:0] d, input logic [2:0] c);
        mc = c;
        if (d >= 8'h20 && d <= 8'h7E) begin
            push_cell(mx, my, d);
            if (mx == COLS - 1) begin
                mx = 0;
                model_nl();
            end else begin
                mx++;
            end
        end else if (d == 8'h0A) begin
            mx = 0;
            model_nl();
        end else if (d == 8'h0D) begin
            mx = 0;
        end else if (d == 8'h08) begin
            if (mx > 0) mx--;
        end else if (d == 8'h0C) begin
            model_clear();
        end
    endtask

    task automatic model_reset();
        mc = 3'b111;
        model_clear();
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] c);
        int n;
        n = 0;
        while (!bus.CH_READY && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.CH_READY) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%0b required 1", bus.CH_READY);
        end
        bus.CH_DATA  = d;
        bus.COLOR    = c;
        bus.CH_VALID = 1'b1;
        @(negedge clk);
        bus.CH_VALID = 1'b0;
        rdy_after    = bus.CH_READY;
        wr_after     = bus.WREN;
    endtask

    task automatic send_m(input logic [7:0] d, input logic [2:0] c);
        send(d, c);
        model_byte(d, c);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (!bus.CH_READY && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.CH_READY) begin
            errors++;
            $display("FAIL idle_timeout: ready=%0b required 1 after %0d cycles", bus.CH_READY, n);
        end
    endtask

    task automatic check_step(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        chk({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_writes: %0d wrong, idx %0d got a=%0d d=%h required a=%0d d=%h",
                     name, bad, first, cap_q[first].a, cap_q[first].d, exp_q[first].a, exp_q[first].d);
        end
        chk({name, "_x"}, 32'(bus.CURSOR_X), 32'(mx));
        chk({name, "_y"}, 32'(bus.CURSOR_Y), 32'(my));
        chk({name, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({name, "_protocol"}, proto_err - proto_seen, 32'd0);
        proto_seen = proto_err;
        cap_q.delete();
        exp_q.delete();
    endtask

    vec_t tbl[12];

    initial begin
        int n;
        logic [7:0] d;
        logic [2:0] c;
        checks     = 0;
        errors     = 0;
        proto_err  = 0;
        proto_seen = 0;
        mx = 0;
        my = 0;
        mc = 3'b111;
        tbl[0]  = '{8'h41, 3'd2, 1, 0, 1,  16'd0,   32'h241, 1'b0, 1'b1};
        tbl[1]  = '{8'h08, 3'd2, 0, 0, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[2]  = '{8'h08, 3'd2, 0, 0, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[3]  = '{8'h01, 3'd2, 0, 0, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[4]  = '{8'h0A, 3'd5, 0, 1, 80, 16'd636, 32'h520, 1'b0, 1'b0};
        tbl[5]  = '{8'h7A, 3'd7, 1, 1, 1,  16'd320, 32'h77A, 1'b0, 1'b1};
        tbl[6]  = '{8'h62, 3'd1, 2, 1, 1,  16'd324, 32'h162, 1'b0, 1'b1};
        tbl[7]  = '{8'h0D, 3'd3, 0, 1, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[8]  = '{8'h7F, 3'd0, 0, 1, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[9]  = '{8'h1F, 3'd0, 0, 1, 0,  16'd0,   32'h0,   1'b1, 1'b0};
        tbl[10] = '{8'h7E, 3'd4, 1, 1, 1,  16'd320, 32'h47E, 1'b0, 1'b1};
        tbl[11] = '{8'h20, 3'd6, 2, 1, 1,  16'd324, 32'h620, 1'b0, 1'b1};

        rst          = 1'b1;
        bus.CH_VALID = 1'b0;
        bus.CH_DATA  = 8'h00;
        bus.COLOR    = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_wren", 32'(bus.WREN), 32'd0);
        chk("rst_ready", 32'(bus.CH_READY), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd1);
        chk("rst_x", 32'(bus.CURSOR_X), 32'd0);
        chk("rst_y", 32'(bus.CURSOR_Y), 32'd0);
        chk("rst_wraddr", 32'(bus.WRADDR), 32'd0);
        chk("rst_wrdata", bus.WRDATA, 32'd0);
        chk("rst_byteen", 32'(bus.BYTEEN), 32'd0);
        rst = 1'b0;
        model_reset();
        wait_idle(10000);
        chk("reset_clear_n", cap_q.size(), 32'd4000);
        if (cap_q.size() == 4000) begin
            chk("reset_clear_last_a", 32'(cap_q[3999].a), 32'd15996);
            chk("reset_clear_last_d", cap_q[3999].d, 32'h720);
        end
        check_step("reset_clear");

        for (int i = 0; i < 12; i++) begin
            send_m(tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d_ready_after", i), 32'(rdy_after), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_wren_after", i), 32'(wr_after), 32'(tbl[i].wr));
            wait_idle(1000);
            chk($sformatf("vec%0d_nw", i), cap_q.size(), 32'(tbl[i].nw));
            if (tbl[i].nw > 0 && cap_q.size() > 0) begin
                chk($sformatf("vec%0d_last_a", i), 32'(cap_q[cap_q.size() - 1].a), 32'(tbl[i].la));
                chk($sformatf("vec%0d_last_d", i), cap_q[cap_q.size() - 1].d, tbl[i].ld);
            end
            chk($sformatf("vec%0d_x", i), 32'(bus.CURSOR_X), 32'(tbl[i].ex));
            chk($sformatf("vec%0d_y", i), 32'(bus.CURSOR_Y), 32'(tbl[i].ey));
            check_step($sformatf("vec%0d", i));
        end

        send_m(8'h0C, 3'd7);
        wait_idle(10000);
        check_step("formfeed");

        for (int i = 0; i < COLS; i++) send_m(8'($urandom_range(32, 126)), 3'($urandom_range(0, 7)));
        wait_idle(1000);
        chk("wrap_n", cap_q.size(), 32'd160);
        if (cap_q.size() >= 160) begin
            chk("wrap_last_put", 32'(cap_q[79].a), 32'd316);
            chk("wrap_first_clr", 32'(cap_q[80].a), 32'd320);
            chk("wrap_last_clr", 32'(cap_q[159].a), 32'd636);
        end
        check_step("line_wrap");

        for (int i = 0; i < ROWS - 2; i++) send_m(8'h0A, 3'($urandom_range(0, 7)));
        wait_idle(1000);
        check_step("to_row49");
        send_m(8'h0A, 3'd3);
        wait_idle(1000);
        chk("bottom_n", cap_q.size(), 32'd80);
        if (cap_q.size() >= 80) begin
            chk("bottom_first_a", 32'(cap_q[0].a), 32'd0);
            chk("bottom_last_a", 32'(cap_q[79].a), 32'd316);
        end
        chk("bottom_x", 32'(bus.CURSOR_X), 32'd0);
        chk("bottom_y", 32'(bus.CURSOR_Y), 32'd0);
        check_step("bottom_wrap");

        for (int i = 0; i < 3; i++) send_m(8'h0A, 3'd1);
        for (int i = 0; i < 5; i++) send_m(8'h30 + 8'(i), 3'd2);
        wait_idle(1000);
        chk("at53_x", 32'(bus.CURSOR_X), 32'd5);
        chk("at53_y", 32'(bus.CURSOR_Y), 32'd3);
        check_step("goto53");
        send_m(8'h0D, 3'd2);
        chk("cr_ready_next", 32'(rdy_after), 32'd1);
        chk("cr_x", 32'(bus.CURSOR_X), 32'd0);
        chk("cr_y", 32'(bus.CURSOR_Y), 32'd3);
        check_step("cr");

        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 9);
            c = 3'($urandom_range(0, 7));
            if (n == 0) d = 8'h0A;
            else if (n == 1) d = 8'h0D;
            else if (n == 2) d = 8'h08;
            else if (n == 3) begin
                d = 8'($urandom_range(0, 255));
                if ((d >= 8'h20 && d <= 8'h7E) || d == 8'h0A || d == 8'h0D || d == 8'h08 || d == 8'h0C) d = 8'h7F;
            end else d = 8'($urandom_range(32, 126));
            send_m(d, c);
            wait_idle(1000);
            check_step($sformatf("rand%0d", i));
        end

        send(8'h0C, 3'd1);
        n = 0;
        while (!(bus.WREN && bus.WRADDR == 16'd4000) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("midclr_reach", 32'(bus.WREN && bus.WRADDR == 16'd4000), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midclr_wren", 32'(bus.WREN), 32'd0);
        chk("midclr_busy", 32'(bus.BUSY), 32'd1);
        chk("midclr_wraddr", 32'(bus.WRADDR), 32'd0);
        @(negedge clk);
        cap_q.delete();
        exp_q.delete();
        rst = 1'b0;
        model_reset();
        wait_idle(10000);
        if (cap_q.size() > 0) chk("midclr_restart_a", 32'(cap_q[0].a), 32'd0);
        check_step("midclr_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
